sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; successor to the fixed 16x8 synchronous FIFO.
- Generalised data width and depth, with the same extended-pointer (MSB wrap bit) empty/full scheme.
- Adds:
  - registered occupancy count
  - programmable almost-full / almost-empty thresholds
  - overflow / underflow error pulses
  - selectable first-word-fall-through (FWFT) read mode
- Used as the generic buffering primitive between producer/consumer blocks in one clock domain.

Parameters:
- DATA_W, 8, data word width in bits
- ADDR_W, 4, address width; depth DEPTH = 2**ADDR_W (ADDR_W >= 1)
- AF_THRESH, 12, almost_full asserted when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- write_enable  input  1  write request
- write_data  input  DATA_W  write word
- read_enable  input  1  read request (pop in FWFT mode)
- read_data  output  DATA_W  read word
- empty  output  1  no stored words
- full  output  1  DEPTH words stored
- almost_empty  output  1  count <= AE_THRESH
- almost_full  output  1  count >= AF_THRESH
- data_count  output  ADDR_W+1  words stored, 0..DEPTH
- overflow  output  1  one-cycle pulse: write attempted while full
- underflow  output  1  one-cycle pulse: read attempted while empty

Behaviour:
- Reset:
  - Single clock clk; reset rst_n is synchronous and active-low, sampled on the rising edge of clk only.
  - While rst_n = 0 at a clk edge: w_ptr = r_ptr = 0, read_data = 0, overflow = underflow = 0.
  - Consequently empty = 1, full = 0, data_count = 0, almost_empty = 1, almost_full = (AF_THRESH == 0 ? 1 : 0).
  - Memory contents are not reset.
- Pointers:
  - w_ptr and r_ptr are ADDR_W+1 bits; the low ADDR_W bits address memory; increment wraps modulo 2**(ADDR_W+1).
- Flags (combinational from registered pointers; valid in the cycle after the edge that updates them):
  - empty = (w_ptr == r_ptr).
  - full = MSBs differ and low ADDR_W bits equal.
  - data_count = w_ptr - r_ptr (ADDR_W+1 bit modular subtract).
  - almost_full and almost_empty compare against data_count.
- Write:
  - Accepted iff write_enable = 1 and full = 0 at the edge.
  - On accept: mem[w_ptr[ADDR_W-1:0]] <= write_data; w_ptr++.
- Read:
  - Accepted iff read_enable = 1 and empty = 0 at the edge.
  - On accept: r_ptr++.
- FWFT = 0:
  - On accepted read, read_data <= mem[r_ptr] (data valid the cycle after the request).
  - Otherwise read_data holds its last value.
- FWFT = 1:
  - read_data = mem[r_ptr[ADDR_W-1:0]] combinationally whenever empty = 0; it is the head word before the pop.
  - While empty = 1, read_data is don't-care.
  - read_enable consumes the displayed word.
- Simultaneous events:
  - Read and write in the same cycle are both evaluated against pre-edge flags.
  - Not empty and not full: both happen; data_count unchanged.
  - Empty: only the write happens; underflow pulses if read_enable = 1. In FWFT mode the word appears on read_data the next cycle.
  - Full: only the read happens; overflow pulses if write_enable = 1; the rejected word is dropped.
- Error pulses:
  - overflow <= write_enable & full; underflow <= read_enable & empty.
  - Registered, high for exactly one cycle per offending cycle; no pointer or memory change.
- Wrap-around:
  - After 2**(ADDR_W+1) total writes, pointers return to 0; flags stay correct across the wrap.
- Reset mid-operation:
  - Stored data is discarded logically (empty = 1 next cycle); requests in the reset cycle are ignored and do not pulse the error flags.

Test Plan:
- Defaults; write 16 words 0x00..0x0F, no reads:
  - full = 1 after the 16th edge; data_count = 16; almost_full first asserts when count reaches 12.
  - A 17th write gives overflow = 1 for one cycle; data_count stays 16.
- FWFT = 0; read 16 words:
  - read_data = 0x00..0x0F, each one cycle after its read_enable.
  - empty = 1 after the last read; an extra read gives underflow pulse; read_data holds 0x0F.
- Simultaneous read and write at count = 5 for 20 cycles:
  - data_count stays 5; output order matches input order; pointers wrap past 31 correctly.
- Simultaneous read and write on empty, and on full:
  - On empty: count becomes 1, underflow pulses.
  - On full: count becomes 15, overflow pulses, the dropped word never appears.
- FWFT = 1, DATA_W = 16, ADDR_W = 3; write 0xA5A5:
  - read_data = 0xA5A5 the cycle after the write, with no read_enable.
  - Pop → empty = 1.
- Load 7 words, then rst_n = 0 for one edge while write_enable = read_enable = 1:
  - Next cycle: empty = 1, data_count = 0, read_data = 0, no error pulses.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised single-clock FIFO with extended-pointer full/empty detection.
//
// Parameters:
//   DATA_W    - word width in bits
//   ADDR_W    - address width; depth is 2**ADDR_W
//   AF_THRESH - almost_full asserts when data_count >= AF_THRESH
//   AE_THRESH - almost_empty asserts when data_count <= AE_THRESH
//   FWFT      - 0: read_data is registered on an accepted read
//               1: read_data shows the head word combinationally (first-word-fall-through)
//
// Ports:
//   clk          - rising-edge clock
//   rst_n        - synchronous active-low reset
//   write_enable - write request; ignored while full
//   write_data   - word to write
//   read_enable  - read request (pop in FWFT mode); ignored while empty
//   read_data    - read word
//   empty, full  - occupancy flags
//   almost_empty - data_count <= AE_THRESH
//   almost_full  - data_count >= AF_THRESH
//   data_count   - words stored, 0..DEPTH
//   overflow     - one-cycle pulse after a write attempted while full
//   underflow    - one-cycle pulse after a read attempted while empty
module sync_fifo_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned AF_THRESH = 12,
    parameter int unsigned AE_THRESH = 2,
    parameter int unsigned FWFT      = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_enable,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_enable,
    output logic [DATA_W-1:0] read_data,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   data_count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W:0] PtrOne = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] AfThr  = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AeThr  = (ADDR_W + 1)'(AE_THRESH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W:0] w_ptr_q, w_ptr_d;
    logic [ADDR_W:0] r_ptr_q, r_ptr_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;

    logic            wr_accept;
    logic            rd_accept;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] head_word;

    assign wr_addr   = w_ptr_q[ADDR_W-1:0];
    assign rd_addr   = r_ptr_q[ADDR_W-1:0];
    assign head_word = mem_q[rd_addr];

    // Flags derive from registered pointers only; the MSB acts as a lap bit.
    assign empty        = (w_ptr_q == r_ptr_q);
    assign full         = (w_ptr_q[ADDR_W] != r_ptr_q[ADDR_W]) && (wr_addr == rd_addr);
    assign data_count   = w_ptr_q - r_ptr_q;
    assign almost_full  = (data_count >= AfThr);
    assign almost_empty = (data_count <= AeThr);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Both requests are judged against the pre-edge flags.
    assign wr_accept = write_enable && !full;
    assign rd_accept = read_enable && !empty;

    always_comb begin
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        overflow_d  = write_enable && full;
        underflow_d = read_enable && empty;
        if (wr_accept) begin
            w_ptr_d = w_ptr_q + PtrOne;
        end
        if (rd_accept) begin
            r_ptr_d = r_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && wr_accept) begin
            mem_q[wr_addr] <= write_data;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is shown directly; forced to zero while empty to keep it deterministic.
        assign read_data = empty ? '0 : head_word;
    end else begin : g_std
        logic [DATA_W-1:0] rdata_q, rdata_d;

        always_comb begin
            rdata_d = rdata_q;
            if (rd_accept) begin
                rdata_d = head_word;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign read_data = rdata_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param: a default standard-read instance (8x16)
// and a FWFT instance (16x8) sharing one clock and reset.
module tb_sync_fifo_param;

    logic clk;
    logic rst_n;

    // Instance A: defaults (DATA_W=8, ADDR_W=4, AF=12, AE=2, FWFT=0)
    logic        a_we, a_re;
    logic [7:0]  a_wdata, a_rdata;
    logic        a_empty, a_full, a_ae, a_af, a_ovf, a_unf;
    logic [4:0]  a_count;

    // Instance B: DATA_W=16, ADDR_W=3, AF=6, AE=1, FWFT=1
    logic        b_we, b_re;
    logic [15:0] b_wdata, b_rdata;
    logic        b_empty, b_full, b_ae, b_af, b_ovf, b_unf;
    logic [3:0]  b_count;

    int n_checks;
    int n_errors;

    sync_fifo_param u_dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_enable (a_we),
        .write_data   (a_wdata),
        .read_enable  (a_re),
        .read_data    (a_rdata),
        .empty        (a_empty),
        .full         (a_full),
        .almost_empty (a_ae),
        .almost_full  (a_af),
        .data_count   (a_count),
        .overflow     (a_ovf),
        .underflow    (a_unf)
    );

    sync_fifo_param #(
        .DATA_W    (16),
        .ADDR_W    (3),
        .AF_THRESH (6),
        .AE_THRESH (1),
        .FWFT      (1)
    ) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_enable (b_we),
        .write_data   (b_wdata),
        .read_enable  (b_re),
        .read_data    (b_rdata),
        .empty        (b_empty),
        .full         (b_full),
        .almost_empty (b_ae),
        .almost_full  (b_af),
        .data_count   (b_count),
        .overflow     (b_ovf),
        .underflow    (b_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write_word(input logic [7:0] d);
        a_we    = 1'b1;
        a_wdata = d;
        step();
        a_we    = 1'b0;
    endtask

    task automatic a_read_expect(input string tag, input logic [7:0] d);
        a_re = 1'b1;
        step();
        a_re = 1'b0;
        check_value(tag, 32'(a_rdata), 32'(d));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        a_we = 1'b0; a_re = 1'b0; a_wdata = '0;
        b_we = 1'b0; b_re = 1'b0; b_wdata = '0;

        // Reset state
        step();
        step();
        rst_n = 1'b1;
        check_value("rst_empty", 32'(a_empty), 32'd1);
        check_value("rst_full", 32'(a_full), 32'd0);
        check_value("rst_count", 32'(a_count), 32'd0);
        check_value("rst_ae", 32'(a_ae), 32'd1);
        check_value("rst_af", 32'(a_af), 32'd0);
        check_value("rst_rdata", 32'(a_rdata), 32'd0);
        check_value("rst_ovf", 32'(a_ovf), 32'd0);
        check_value("rst_unf", 32'(a_unf), 32'd0);
        check_value("rst_b_empty", 32'(b_empty), 32'd1);

        // Fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            a_write_word(8'(i));
            check_value("fill_count", 32'(a_count), 32'(i + 1));
            check_value("fill_af", 32'(a_af), 32'((i + 1) >= 12));
            check_value("fill_ae", 32'(a_ae), 32'((i + 1) <= 2));
            check_value("fill_full", 32'(a_full), 32'((i + 1) == 16));
        end

        // Write while full
        a_write_word(8'hEE);
        check_value("ovf_pulse", 32'(a_ovf), 32'd1);
        check_value("ovf_count", 32'(a_count), 32'd16);
        step();
        check_value("ovf_clear", 32'(a_ovf), 32'd0);

        // Drain, data one cycle after request
        for (int i = 0; i < 16; i++) begin
            a_read_expect("drain_data", 8'(i));
            check_value("drain_count", 32'(a_count), 32'(15 - i));
        end
        check_value("drain_empty", 32'(a_empty), 32'd1);

        // Read while empty
        a_re = 1'b1;
        step();
        a_re = 1'b0;
        check_value("unf_pulse", 32'(a_unf), 32'd1);
        check_value("unf_hold", 32'(a_rdata), 32'h0F);
        step();
        check_value("unf_clear", 32'(a_unf), 32'd0);

        // Steady state at count 5 across the pointer wrap
        for (int i = 0; i < 5; i++) a_write_word(8'(8'h40 + i));
        check_value("ss_pre_count", 32'(a_count), 32'd5);
        for (int k = 0; k < 20; k++) begin
            a_we    = 1'b1;
            a_re    = 1'b1;
            a_wdata = 8'(8'h45 + k);
            step();
            check_value("ss_data", 32'(a_rdata), 32'(8'h40 + k));
            check_value("ss_count", 32'(a_count), 32'd5);
        end
        a_we = 1'b0;
        a_re = 1'b0;
        for (int i = 0; i < 5; i++) a_read_expect("ss_tail", 8'(8'h54 + i));
        check_value("ss_empty", 32'(a_empty), 32'd1);

        // Simultaneous read/write on empty: only the write lands
        a_we    = 1'b1;
        a_re    = 1'b1;
        a_wdata = 8'h77;
        step();
        a_we = 1'b0;
        a_re = 1'b0;
        check_value("se_count", 32'(a_count), 32'd1);
        check_value("se_unf", 32'(a_unf), 32'd1);
        check_value("se_hold", 32'(a_rdata), 32'h58);

        // Fill to full, then simultaneous read/write on full: only the read lands
        for (int i = 0; i < 15; i++) a_write_word(8'(8'h80 + i));
        check_value("sf_pre_full", 32'(a_full), 32'd1);
        a_we    = 1'b1;
        a_re    = 1'b1;
        a_wdata = 8'hDD;
        step();
        a_we = 1'b0;
        a_re = 1'b0;
        check_value("sf_count", 32'(a_count), 32'd15);
        check_value("sf_ovf", 32'(a_ovf), 32'd1);
        check_value("sf_data", 32'(a_rdata), 32'h77);
        for (int i = 0; i < 15; i++) a_read_expect("sf_drain", 8'(8'h80 + i));
        check_value("sf_empty", 32'(a_empty), 32'd1);

        // FWFT instance
        b_we    = 1'b1;
        b_wdata = 16'hA5A5;
        step();
        b_we = 1'b0;
        check_value("fw_head", 32'(b_rdata), 32'hA5A5);
        check_value("fw_count", 32'(b_count), 32'd1);
        step();
        check_value("fw_hold", 32'(b_rdata), 32'hA5A5);
        b_re = 1'b1;
        step();
        b_re = 1'b0;
        check_value("fw_pop_empty", 32'(b_empty), 32'd1);
        check_value("fw_pop_count", 32'(b_count), 32'd0);
        b_we = 1'b1;
        b_wdata = 16'h1111;
        step();
        b_wdata = 16'h2222;
        step();
        b_we = 1'b0;
        check_value("fw_head1", 32'(b_rdata), 32'h1111);
        b_re = 1'b1;
        step();
        check_value("fw_head2", 32'(b_rdata), 32'h2222);
        step();
        b_re = 1'b0;
        check_value("fw_empty2", 32'(b_empty), 32'd1);
        for (int i = 0; i < 8; i++) begin
            b_we    = 1'b1;
            b_wdata = 16'(16'h0100 + i);
            step();
        end
        b_we = 1'b0;
        check_value("fw_full", 32'(b_full), 32'd1);
        check_value("fw_af", 32'(b_af), 32'd1);
        check_value("fw_full_head", 32'(b_rdata), 32'h0100);

        // Reset mid-operation on A with requests active
        for (int i = 0; i < 7; i++) a_write_word(8'(8'hC0 + i));
        a_read_expect("mr_pre_read", 8'hC0);
        check_value("mr_pre_count", 32'(a_count), 32'd6);
        rst_n = 1'b0;
        a_we  = 1'b1;
        a_re  = 1'b1;
        a_wdata = 8'hFF;
        step();
        rst_n = 1'b1;
        a_we  = 1'b0;
        a_re  = 1'b0;
        check_value("mr_empty", 32'(a_empty), 32'd1);
        check_value("mr_count", 32'(a_count), 32'd0);
        check_value("mr_rdata", 32'(a_rdata), 32'd0);
        check_value("mr_ovf", 32'(a_ovf), 32'd0);
        check_value("mr_unf", 32'(a_unf), 32'd0);
        check_value("mr_b_empty", 32'(b_empty), 32'd1);
        step();
        check_value("mr_unf_after", 32'(a_unf), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
